// File: rtl/rambus_sample_reader.sv
// Reads a word table over a Wishbone master port and streams it out byte by byte, LSB first.
// Define RAMBUS_TIMEOUT_EN to abort a read after 255 ack-less cycles and raise sticky error_o.
module rambus_sample_reader #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        loop_i,
  input  logic [9:0]  base_addr_i,
  input  logic [7:0]  length_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        rambus_wb_clk_o,
  output logic        rambus_wb_rst_o,
  output logic        rambus_wb_stb_o,
  output logic        rambus_wb_cyc_o,
  output logic        rambus_wb_we_o,
  output logic [3:0]  rambus_wb_sel_o,
  output logic [31:0] rambus_wb_dat_o,
  output logic [9:0]  rambus_wb_adr_o,
  input  logic        rambus_wb_ack_i,
  input  logic [31:0] rambus_wb_dat_i,
  output logic [7:0]  sample_o,
  output logic        sample_valid_o,
  input  logic        sample_ready_i
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_SPACE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          cyc_q, cyc_d, stop_pend_q, stop_pend_d, loop_q, loop_d;
  logic [7:0]    base_q, base_d, word_addr_q, word_addr_d;
  logic [7:0]    len_q, len_d, word_cnt_q, word_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ser_word_q, ser_word_d;
  logic [1:0]    ser_cnt_q, ser_cnt_d;
  logic          ser_valid_q, ser_valid_d;
  logic          push, pop, flush, last_word, fire, timeout;
  logic [8:0]    len_ext;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic          unused_addr_bits;

  assign unused_addr_bits = ^base_addr_i[1:0];

`ifdef RAMBUS_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;
  assign to_cnt_d = (state_q == REQ) ? to_cnt_q + 8'd1 : '0;
  assign timeout  = (state_q == REQ) && (to_cnt_q == 8'd254);
  assign error_o  = err_q;
`else
  assign timeout  = 1'b0;
  assign error_o  = 1'b0;
`endif

  assign len_ext   = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
  assign last_word = ({1'b0, word_cnt_q} + 9'd1) == len_ext;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cyc_d       = cyc_q;
    stop_pend_d = stop_pend_q;
    loop_d      = loop_q;
    base_d      = base_q;
    word_addr_d = word_addr_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    push        = 1'b0;
    flush       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          base_d      = base_addr_i[9:2];
          word_addr_d = base_addr_i[9:2];
          len_d       = length_i;
          loop_d      = loop_i;
          word_cnt_d  = '0;
          busy_d      = 1'b1;
          err_d       = 1'b0;
          state_d     = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (stop_i) begin
          flush   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (count_q != FIFO_FULL) begin
          cyc_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (stop_i) stop_pend_d = 1'b1;
        // An abort must still wait for the slave's ack; the returned word is dropped.
        if (rambus_wb_ack_i) begin
          cyc_d = 1'b0;
          if (stop_pend_q || stop_i) begin
            flush       = 1'b1;
            busy_d      = 1'b0;
            stop_pend_d = 1'b0;
            state_d     = IDLE;
          end else begin
            push = 1'b1;
            if (!last_word) begin
              word_cnt_d  = word_cnt_q + 8'd1;
              word_addr_d = word_addr_q + 8'd1;
              state_d     = WAIT_SPACE;
            end else if (loop_q) begin
              word_cnt_d  = '0;
              word_addr_d = base_q;
              state_d     = WAIT_SPACE;
            end else begin
              state_d = DRAIN;
            end
          end
        end else if (timeout) begin
          cyc_d       = 1'b0;
          err_d       = 1'b1;
          flush       = 1'b1;
          busy_d      = 1'b0;
          stop_pend_d = 1'b0;
          state_d     = IDLE;
        end
      end
      DRAIN: begin
        if (stop_i) begin
          flush   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (count_q == '0 && !ser_valid_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fire = ser_valid_q && sample_ready_i;

  // Reloading on the last byte's handshake keeps the stream at one byte per cycle.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ser_word_d  = ser_word_q;
    ser_cnt_d   = ser_cnt_q;
    ser_valid_d = ser_valid_q;
    pop         = 1'b0;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      ser_word_d  = '0;
      ser_cnt_d   = '0;
      ser_valid_d = 1'b0;
    end else begin
      if ((!ser_valid_q || (fire && ser_cnt_q == 2'd3)) && count_q != '0) begin
        pop         = 1'b1;
        ser_word_d  = fifo_mem[rd_ptr_q];
        ser_cnt_d   = '0;
        ser_valid_d = 1'b1;
      end else if (fire) begin
        ser_word_d = {8'h00, ser_word_q[31:8]};
        ser_cnt_d  = ser_cnt_q + 2'd1;
        if (ser_cnt_q == 2'd3) ser_valid_d = 1'b0;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cyc_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      loop_q      <= 1'b0;
      base_q      <= '0;
      word_addr_q <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ser_word_q  <= '0;
      ser_cnt_q   <= '0;
      ser_valid_q <= 1'b0;
`ifdef RAMBUS_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cyc_q       <= cyc_d;
      stop_pend_q <= stop_pend_d;
      loop_q      <= loop_d;
      base_q      <= base_d;
      word_addr_q <= word_addr_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ser_word_q  <= ser_word_d;
      ser_cnt_q   <= ser_cnt_d;
      ser_valid_q <= ser_valid_d;
`ifdef RAMBUS_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_n_i && push) fifo_mem[wr_ptr_q] <= rambus_wb_dat_i;
  end

  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = ~wb_rst_n_i;
  assign rambus_wb_we_o  = 1'b0;
  assign rambus_wb_sel_o = 4'hF;
  assign rambus_wb_dat_o = '0;
  assign rambus_wb_cyc_o = cyc_q;
  assign rambus_wb_stb_o = cyc_q;
  assign rambus_wb_adr_o = {word_addr_q, 2'b00};
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign sample_o        = ser_word_q[7:0];
  assign sample_valid_o  = ser_valid_q;

endmodule

// File: tb/tb_rambus_sample_reader.sv
// Directed bench for rambus_sample_reader: Wishbone RAM responder plus byte/address scoreboards.
module tb_rambus_sample_reader;
  localparam int DEPTH = 4;

  logic        clk, rst_n, start, stop, loop_r, ack, stb, cyc, we, wbclk, wbrst;
  logic        busy, done, err, svalid, sready;
  logic [9:0]  base, adr;
  logic [7:0]  len, sample;
  logic [3:0]  sel;
  logic [31:0] dato, dati;

  rambus_sample_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start), .stop_i(stop), .loop_i(loop_r),
    .base_addr_i(base), .length_i(len), .busy_o(busy), .done_o(done), .error_o(err),
    .rambus_wb_clk_o(wbclk), .rambus_wb_rst_o(wbrst), .rambus_wb_stb_o(stb),
    .rambus_wb_cyc_o(cyc), .rambus_wb_we_o(we), .rambus_wb_sel_o(sel),
    .rambus_wb_dat_o(dato), .rambus_wb_adr_o(adr), .rambus_wb_ack_i(ack),
    .rambus_wb_dat_i(dati), .sample_o(sample), .sample_valid_o(svalid),
    .sample_ready_i(sready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0, n_fail = 0;
  logic [31:0] ram [256];
  logic [7:0]  exp_bytes [$];
  logic [9:0]  exp_adr [$];
  int fire_cyc [$];
  int  ack_delay = 0, wait_cnt = 0, n_reads = 0, rdy_mode = 0, cyc_n = 0;
  int  n_bytes = 0, done_cnt = 0, words_loaded = 0, byte_pos = 0, full_viol = 0;
  bit  ack_en = 1, chk_bytes = 1, chk_adr = 1, presented = 0;
  logic prev_valid = 0, prev_fire = 0;
  logic [7:0] prev_sample = 0;

  // Monitor and RAM responder share one process so occupancy is modelled before n_reads moves.
  initial begin : mon
    logic fire;
    logic [9:0] ea;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      cyc_n++;
      sready = (rdy_mode == 0) ? 1'b1 : (cyc_n % 4 == 0);
      if (done) done_cnt++;
      if (!rst_n) begin
        ack = 1'b0; wait_cnt = 0; prev_valid = 0; prev_fire = 0;
      end else begin
        if (cyc && (n_reads - words_loaded) >= DEPTH) full_viol++;
        if (svalid && byte_pos == 0 && !presented) begin
          words_loaded++; presented = 1;
        end
        if (chk_bytes && prev_valid && !prev_fire) begin
          n_checks++;
          assert (svalid === 1'b1 && sample === prev_sample) else begin
            n_fail++;
            $error("FAIL stall_hold: observed valid=%b sample=%h expected valid=1 sample=%h", svalid, sample, prev_sample);
          end
        end
        fire = svalid && sready;
        if (fire) begin
          n_bytes++;
          fire_cyc.push_back(cyc_n);
          if (chk_bytes) begin
            eb = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : 8'hxx;
            n_checks++;
            assert (sample === eb) else begin
              n_fail++;
              $error("FAIL byte: observed %h expected %h", sample, eb);
            end
          end
          byte_pos = (byte_pos + 1) % 4;
          if (byte_pos == 0) presented = 0;
        end
        prev_valid = svalid; prev_fire = fire; prev_sample = sample;
        if (ack) begin
          ack = 1'b0; wait_cnt = 0;
        end else if (cyc) begin
          if (ack_en && wait_cnt >= ack_delay) begin
            ack = 1'b1;
            dati = ram[adr[9:2]];
            n_reads++;
            if (chk_adr) begin
              ea = (exp_adr.size() != 0) ? exp_adr.pop_front() : 10'hxxx;
              n_checks++;
              assert (adr === ea) else begin
                n_fail++;
                $error("FAIL read_adr: observed %h expected %h", adr, ea);
              end
            end
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic clear_sb();
    exp_bytes.delete(); exp_adr.delete(); fire_cyc.delete();
    n_reads = 0; n_bytes = 0; done_cnt = 0; words_loaded = 0; byte_pos = 0;
    presented = 0; full_viol = 0; prev_valid = 0; prev_fire = 0;
  endtask

  task automatic expect_word(input logic [7:0] widx, input logic [31:0] w);
    ram[widx] = w;
    exp_adr.push_back({widx, 2'b00});
    for (int unsigned b = 0; b < 4; b++) exp_bytes.push_back(w[8*b +: 8]);
  endtask

  task automatic start_op(input logic [9:0] b, input logic [7:0] l, input logic lp);
    base = b; len = l; loop_r = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin : stim
    int n;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_r = 1'b0; base = '0; len = '0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_cyc_stb", {30'd0, cyc, stb}, 0);
    chk("rst_valid", {31'd0, svalid}, 0);
    chk("rst_adr_sample", {14'd0, adr, sample}, 0);
    chk("rst_wbrst", {31'd0, wbrst}, 1);
    chk("const_we_sel", {27'd0, we, sel}, 32'h0000000F);
    chk("const_dat", dato, 0);
    rst_n = 1'b1;
    tick();
    chk("wbrst_released", {31'd0, wbrst}, 0);

    // stop together with start: start must not take effect
    base = 10'h010; len = 8'd1; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    chk("stopstart_busy", {31'd0, busy}, 0);
    chk("stopstart_cyc", {31'd0, cyc}, 0);

    // single word
    clear_sb();
    expect_word(8'h04, 32'h44332211);
    start_op(10'h010, 8'd1, 1'b0);
    chk("single_busy", {31'd0, busy}, 1);
    wait_idle(100, "single_idle");
    chk("single_done", done_cnt, 1);
    chk("single_left", exp_bytes.size() + exp_adr.size(), 0);
    chk("single_nbytes", fire_cyc.size(), 4);
    if (fire_cyc.size() == 4) chk("single_consec", fire_cyc[3] - fire_cyc[0], 3);

    // backpressure, with a start pulse mid-run that must be ignored
    clear_sb();
    for (int unsigned i = 0; i < 8; i++) expect_word(8'(64 + i), $urandom);
    rdy_mode = 1;
    start_op(10'h100, 8'd8, 1'b0);
    repeat (20) tick();
    start_op(10'h3F0, 8'd1, 1'b0);
    wait_idle(1500, "bp_idle");
    rdy_mode = 0;
    chk("bp_nbytes", n_bytes, 32);
    chk("bp_reads", n_reads, 8);
    chk("bp_left", exp_bytes.size() + exp_adr.size(), 0);
    chk("bp_done", done_cnt, 1);
    chk("bp_full_req", full_viol, 0);

    // address wrap
    clear_sb();
    expect_word(8'hFF, 32'hA1B2C3D4);
    expect_word(8'h00, 32'h0F1E2D3C);
    start_op(10'h3FC, 8'd2, 1'b0);
    wait_idle(100, "wrap_idle");
    chk("wrap_left", exp_bytes.size() + exp_adr.size(), 0);
    chk("wrap_done", done_cnt, 1);

    // length 0 means 256 words
    clear_sb();
    for (int unsigned i = 0; i < 256; i++) expect_word(8'(i), {8'(i), 8'(~i), 8'(i ^ 8'h5A), 8'(i + 3)});
    start_op(10'h000, 8'd0, 1'b0);
    wait_idle(3000, "len256_idle");
    chk("len256_reads", n_reads, 256);
    chk("len256_left", exp_bytes.size() + exp_adr.size(), 0);
    chk("len256_done", done_cnt, 1);

    // loop then stop during a delayed-ack read
    clear_sb();
    chk_bytes = 0; ack_delay = 5;
    exp_adr.push_back(10'h040); exp_adr.push_back(10'h044); exp_adr.push_back(10'h048);
    exp_adr.push_back(10'h040); exp_adr.push_back(10'h044);
    start_op(10'h040, 8'd3, 1'b1);
    n = 0;
    while (!(n_reads == 4 && cyc && !ack) && n < 300) begin
      tick();
      n++;
    end
    chk("loop_reads", n_reads, 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_cyc_hold", {31'd0, cyc}, 1);
    n = 0;
    while (!ack && n < 20) begin
      tick();
      n++;
    end
    chk("stop_ack_seen", {31'd0, ack}, 1);
    chk("stop_cyc_at_ack", {31'd0, cyc}, 1);
    tick();
    chk("stop_busy", {31'd0, busy}, 0);
    chk("stop_cyc", {31'd0, cyc}, 0);
    chk("stop_flush", {31'd0, svalid}, 0);
    repeat (5) tick();
    chk("stop_nodone", done_cnt, 0);
    chk("stop_reads", n_reads, 5);
    chk("stop_adr_left", exp_adr.size(), 0);
    ack_delay = 0; chk_bytes = 1;

    // reset during an active read
    clear_sb();
    chk_bytes = 0; chk_adr = 0; ack_delay = 3;
    start_op(10'h080, 8'd4, 1'b0);
    n = 0;
    while (!(n_reads >= 2 && cyc && !ack) && n < 200) begin
      tick();
      n++;
    end
    chk("midrst_cyc_before", {31'd0, cyc}, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_cyc_stb", {30'd0, cyc, stb}, 0);
    chk("midrst_valid", {31'd0, svalid}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_adr_sample", {14'd0, adr, sample}, 0);
    rst_n = 1'b1;
    tick();
    ack_delay = 0;
    clear_sb();
    chk_bytes = 1; chk_adr = 1;
    expect_word(8'h05, 32'hDDCCBBAA);
    start_op(10'h017, 8'd1, 1'b0);
    wait_idle(100, "afterrst_idle");
    chk("afterrst_left", exp_bytes.size() + exp_adr.size(), 0);
    chk("afterrst_done", done_cnt, 1);

`ifdef RAMBUS_TIMEOUT_EN
    clear_sb();
    ack_en = 0; chk_adr = 0;
    start_op(10'h020, 8'd1, 1'b0);
    n = 0;
    while (!cyc && n < 10) begin
      tick();
      n++;
    end
    n = 0;
    while (cyc && n < 400) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 255);
    chk("to_err", {31'd0, err}, 1);
    chk("to_busy", {31'd0, busy}, 0);
    chk("to_nodone", done_cnt, 0);
    ack_en = 1; chk_adr = 1;
    clear_sb();
    expect_word(8'h08, 32'h87654321);
    start_op(10'h020, 8'd1, 1'b0);
    chk("to_err_clear", {31'd0, err}, 0);
    wait_idle(100, "to_restart_idle");
    chk("to_restart_left", exp_bytes.size() + exp_adr.size(), 0);
`else
    chk("err_tied", {31'd0, err}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
